// File: rtl/game_ctrl_fsm.sv
// Snake game-state controller: start/play/pause/die/restart/gameover
// sequencing, lives tracking and the death blink pattern.
module game_ctrl_fsm #(
  parameter int N_KEYS         = 4,
  parameter int FLASH_HALF     = 25_000_000,
  parameter int FLASH_COUNT    = 3,
  parameter int DIE_CYCLES     = 200_000_000,
  parameter int RESTART_CYCLES = 6,
  parameter int LIVES          = 3,
  parameter int LIVES_W        = $clog2(LIVES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_KEYS-1:0]  key_press,
  input  logic               pause_press,
  input  logic               hit_wall,
  input  logic               hit_body,
  output logic [2:0]         game_status,
  output logic               die_flash,
  output logic               restart,
  output logic               play_en,
  output logic [LIVES_W-1:0] lives,
  output logic               game_over
);

  localparam int MAXC =
    (DIE_CYCLES > RESTART_CYCLES) ? DIE_CYCLES : RESTART_CYCLES;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int FH_W  = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam int FLASH_END = 2 * FLASH_COUNT * FLASH_HALF;

  localparam logic [CNT_W-1:0] DIE_LAST = CNT_W'(DIE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESTART_CYCLES - 1);
  localparam logic [FH_W-1:0]  FH_LAST  = FH_W'(FLASH_HALF - 1);

  typedef enum logic [2:0] {
    S_RESTART  = 3'd0,
    S_START    = 3'd1,
    S_PLAY     = 3'd2,
    S_DIE      = 3'd3,
    S_PAUSE    = 3'd4,
    S_GAMEOVER = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FH_W-1:0]    fcnt_q, fcnt_d;
  logic               flash_d;
  logic [LIVES_W-1:0] lives_d;
  logic               any_key, hit;

  assign any_key     = |key_press;
  assign hit         = hit_wall | hit_body;
  assign game_status = state_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    fcnt_d  = '0;
    flash_d = 1'b1;
    lives_d = lives;
    case (state_q)
      S_START: begin
        if (any_key) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (hit)              state_d = S_DIE;
        else if (pause_press) state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (pause_press) state_d = S_PLAY;
      end
      S_DIE: begin
        if (cnt_q == DIE_LAST) begin
          if (lives == LIVES_W'(1)) begin
            state_d = S_GAMEOVER;
            lives_d = '0;
          end else begin
            state_d = S_RESTART;
            lives_d = lives - LIVES_W'(1);
          end
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          fcnt_d  = fcnt_q + FH_W'(1);
          flash_d = die_flash;
          // Toggle at each half-period boundary inside the blink window
          if (fcnt_q == FH_LAST) begin
            fcnt_d = '0;
            if (32'(cnt_q) < 32'(FLASH_END)) flash_d = ~die_flash;
          end
        end
      end
      S_RESTART: begin
        if (cnt_q == RST_LAST) state_d = S_START;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      S_GAMEOVER: begin
        if (any_key || pause_press) begin
          state_d = S_RESTART;
          lives_d = LIVES_W'(LIVES);
        end
      end
      default: state_d = S_START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_START;
      cnt_q     <= '0;
      fcnt_q    <= '0;
      die_flash <= 1'b1;
      restart   <= 1'b0;
      play_en   <= 1'b0;
      lives     <= LIVES_W'(LIVES);
      game_over <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fcnt_q    <= fcnt_d;
      die_flash <= flash_d;
      restart   <= (state_d == S_RESTART);
      play_en   <= (state_d == S_PLAY);
      lives     <= lives_d;
      game_over <= (state_d == S_GAMEOVER);
    end
  end

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Scoreboard bench for game_ctrl_fsm: directed stimulus queues expected
// output snapshots, a negedge monitor pops and compares them.
module tb_game_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] key_press = '0;
  logic       pause_press = 1'b0;
  logic       hit_wall = 1'b0;
  logic       hit_body = 1'b0;
  logic [2:0] game_status;
  logic       die_flash, restart, play_en, game_over;
  logic [1:0] lives;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      name;
    logic [2:0] st;
    logic       fl;
    logic       rs;
    logic       pe;
    logic [1:0] lv;
    logic       go;
  } exp_t;

  exp_t sb[$];
  logic [19:0] pat = 20'b1111_0000_1111_0000_1111;

  game_ctrl_fsm #(
    .N_KEYS(4), .FLASH_HALF(4), .FLASH_COUNT(2),
    .DIE_CYCLES(20), .RESTART_CYCLES(3), .LIVES(2)
  ) dut (
    .clk(clk), .rst(rst), .key_press(key_press),
    .pause_press(pause_press), .hit_wall(hit_wall), .hit_body(hit_body),
    .game_status(game_status), .die_flash(die_flash), .restart(restart),
    .play_en(play_en), .lives(lives), .game_over(game_over)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [7:0] act, req;
      e = sb.pop_front();
      act = {game_status, die_flash, restart, play_en, lives[1:0]};
      req = {e.st, e.fl, e.rs, e.pe, e.lv};
      checks++;
      if (act !== req || game_over !== e.go) begin
        failures++;
        $display("FAIL %s: got st=%0d fl=%b rs=%b pe=%b lv=%0d go=%b, want st=%0d fl=%b rs=%b pe=%b lv=%0d go=%b",
          e.name, game_status, die_flash, restart, play_en, lives, game_over,
          e.st, e.fl, e.rs, e.pe, e.lv, e.go);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  task automatic cyc(input logic [3:0] k, input logic p,
                     input logic hw, input logic hb);
    @(negedge clk);
    rst = 1'b0; key_press = k; pause_press = p;
    hit_wall = hw; hit_body = hb;
    @(posedge clk);
    #1;
    key_press = '0; pause_press = 1'b0; hit_wall = 1'b0; hit_body = 1'b0;
  endtask

  task automatic rst_cyc();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk(input string n, input logic [2:0] st, input logic fl,
                     input logic rs, input logic pe, input logic [1:0] lv,
                     input logic go);
    exp_t e;
    e.name = n; e.st = st; e.fl = fl; e.rs = rs;
    e.pe = pe; e.lv = lv; e.go = go;
    sb.push_back(e);
  endtask

  // DIE cycles k=1..19 after the entry cycle has already been checked
  task automatic die_rest(input logic [1:0] lv);
    for (int k = 1; k < 20; k++) begin
      cyc(4'b0000, 1'b0, 1'b0, 1'b0);
      chk($sformatf("die_k%0d", k), 3'd3, pat[k], 1'b0, 1'b0, lv, 1'b0);
    end
  endtask

  initial begin
    // 1: reset, START ignores pause, key starts play
    rst_cyc();
    chk("reset", 3'd1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
    cyc(4'b0000, 1'b1, 1'b0, 1'b0);
    chk("start_pause_ignored", 3'd1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0, 1'b1);
    chk("start_hit_ignored", 3'd1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
    cyc(4'b0100, 1'b0, 1'b0, 1'b0);
    chk("start_to_play", 3'd2, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0);

    // 2: pause, hit ignored in pause, resume, hit beats pause
    cyc(4'b0000, 1'b1, 1'b0, 1'b0);
    chk("play_to_pause", 3'd4, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(4'b0001, 1'b0, 1'b1, 1'b0);
      chk($sformatf("pause_hold_%0d", i), 3'd4, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
    end
    cyc(4'b0000, 1'b1, 1'b0, 1'b0);
    chk("pause_to_play", 3'd2, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0);
    cyc(4'b0000, 1'b1, 1'b1, 1'b0);
    chk("hit_beats_pause", 3'd3, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);

    // 3: blink pattern, then restart window
    die_rest(2'd2);
    cyc(4'b0000, 1'b0, 1'b0, 1'b0);
    chk("die_to_restart", 3'd0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0);
    cyc(4'b1111, 1'b1, 1'b1, 1'b1);
    chk("restart_1", 3'd0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0, 1'b1);
    chk("restart_2", 3'd0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0, 1'b0);
    chk("restart_to_start", 3'd1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0);

    // 4: second death ends the game
    cyc(4'b0000, 1'b0, 1'b0, 1'b1);
    chk("start_hitbody_ignored", 3'd1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
    cyc(4'b0001, 1'b0, 1'b0, 1'b0);
    chk("play_again", 3'd2, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0, 1'b1);
    chk("die2_entry", 3'd3, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
    die_rest(2'd1);
    cyc(4'b0000, 1'b0, 1'b0, 1'b0);
    chk("die_to_gameover", 3'd5, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
    cyc(4'b0000, 1'b0, 1'b0, 1'b1);
    chk("gameover_hit_ignored", 3'd5, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
    cyc(4'b1000, 1'b0, 1'b0, 1'b0);
    chk("gameover_to_restart", 3'd0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0, 1'b0);
    chk("go_restart_1", 3'd0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0, 1'b0);
    chk("go_restart_2", 3'd0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0, 1'b0);
    chk("go_restart_to_start", 3'd1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);

    // 5: reset mid-DIE (k=9) and mid-RESTART
    cyc(4'b0010, 1'b0, 1'b0, 1'b0);
    chk("play3", 3'd2, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0);
    cyc(4'b0000, 1'b0, 1'b1, 1'b0);
    chk("die3_entry", 3'd3, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
    for (int k = 1; k <= 9; k++) cyc(4'b0000, 1'b0, 1'b0, 1'b0);
    chk("die3_k9", 3'd3, pat[9], 1'b0, 1'b0, 2'd2, 1'b0);
    rst_cyc();
    chk("rst_mid_die", 3'd1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
    cyc(4'b0001, 1'b0, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0, 1'b1);
    chk("die4_entry", 3'd3, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
    for (int k = 1; k < 20; k++) cyc(4'b0000, 1'b0, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0, 1'b0);
    chk("die4_to_restart", 3'd0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0);
    rst_cyc();
    chk("rst_mid_restart", 3'd1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_ctrl_fsm.md
# game_ctrl_fsm

Parametrised game-state controller for the snake game. Sequences RESTART → START → PLAY → DIE, and adds a PAUSE state, a lives counter and a terminal GAMEOVER state. It drives the blink pattern for the death animation and the restart strobe consumed by the snake, apple and score blocks. It sits between the key debouncers and the game-logic/VGA blocks.

## Interface
Parameters:
- `N_KEYS`, default 4: number of direction-key press inputs.
- `FLASH_HALF`, default 25_000_000: cycles per half-period of the death blink.
- `FLASH_COUNT`, default 3: number of full blink periods (off+on) in DIE.
- `DIE_CYCLES`, default 200_000_000: total cycles spent in DIE. Must be ≥ 2·FLASH_COUNT·FLASH_HALF.
- `RESTART_CYCLES`, default 6: cycles spent in RESTART. Must be ≥ 1.
- `LIVES`, default 3: lives per game. Must be ≥ 1.
- `LIVES_W`, derived as $clog2(LIVES+1): width of the `lives` output.

Ports:
- `clk` in 1: single system clock. Every transition happens on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `key_press` in N_KEYS: one-cycle press pulses, one per direction key.
- `pause_press` in 1: one-cycle press pulse from the pause key.
- `hit_wall` in 1: collision flag from the snake block.
- `hit_body` in 1: collision flag from the snake block.
- `game_status` out 3: state encoding RESTART=0, START=1, PLAY=2, DIE=3, PAUSE=4, GAMEOVER=5.
- `die_flash` out 1: display enable during the death blink; 1 means visible.
- `restart` out 1: active-high. High exactly while `game_status`==RESTART.
- `play_en` out 1: high only in PLAY. The snake mover advances only when this is high.
- `lives` out LIVES_W: lives remaining.
- `game_over` out 1: high only in GAMEOVER.

## Operation
- Reset values: `game_status`=START, `die_flash`=1, `restart`=0, `play_en`=0, `lives`=LIVES, `game_over`=0, internal counter=0. Reset has priority over every other input, including mid-DIE and mid-RESTART.
- `any_key` = OR of all `key_press` bits.
- `hit` = `hit_wall` | `hit_body`.
- START:
  - `any_key` → PLAY.
  - `pause_press` and `hit` are ignored.
- PLAY:
  - `hit` → DIE.
  - Else `pause_press` → PAUSE.
  - If `hit` and `pause_press` arrive in the same cycle, `hit` wins.
- PAUSE:
  - `pause_press` → PLAY.
  - `hit` and `any_key` are ignored.
  - `play_en` is 0.
- DIE:
  - Let k = cycles since entry, with k=0 on the first cycle `game_status` reads DIE.
  - While k < 2·FLASH_COUNT·FLASH_HALF: `die_flash` = 1 when floor(k/FLASH_HALF) is even, else 0.
  - From that point until exit: `die_flash` = 1.
  - On k = DIE_CYCLES−1 the next state is chosen:
    - `lives`==1 → GAMEOVER, with `lives` set to 0.
    - Otherwise `lives` is decremented and the next state is RESTART.
  - The counter clears on exit. All inputs are ignored.
- RESTART:
  - `restart`=1 for exactly RESTART_CYCLES cycles, then → START with `restart`=0.
  - `lives` is unchanged. All inputs are ignored.
- GAMEOVER:
  - `game_over`=1, `die_flash`=1.
  - `any_key` or `pause_press` → RESTART, and `lives` reloads to LIVES on the same edge.
- Counter:
  - Width is $clog2(max(DIE_CYCLES, RESTART_CYCLES)).
  - Shared between DIE and RESTART, and zero whenever the state is not DIE or RESTART.
  - It never wraps: the state always exits at the terminal count.
- `lives` changes only on the DIE exit edge, the GAMEOVER → RESTART edge, and reset.

## Timing
- All outputs are registered and change on the same edge as `game_status`. There are no combinational input-to-output paths.
- Input-to-state latency is 1 cycle: a pulse sampled at edge n produces the new `game_status` after edge n.
- DIE occupies exactly DIE_CYCLES cycles. RESTART occupies exactly RESTART_CYCLES cycles.
- START and PAUSE wait indefinitely.
- `die_flash` transitions occur at k = FLASH_HALF, 2·FLASH_HALF, … up to 2·FLASH_COUNT·FLASH_HALF, measured from DIE entry.
- Single-cycle pulses are sufficient. A level held high on `pause_press` toggles PLAY/PAUSE every cycle; the debouncers must deliver one pulse per press.
- `hit` is level-sensitive and is sampled only in PLAY.

## Test plan
Parameters for all scenarios: FLASH_HALF=4, FLASH_COUNT=2, DIE_CYCLES=20, RESTART_CYCLES=3, LIVES=2.

1. Reset, then `key_press`=4'b0100 for 1 cycle → `game_status` 1→2 one cycle later, `play_en`=1, `lives`=2. Driving `pause_press` only while in START leaves the state at 1.
2. In PLAY, pulse `pause_press` → 4 with `play_en`=0. Then raise `hit_wall` for 5 cycles → the state stays 4. Pulse `pause_press` → 2. Assert `hit_wall` and `pause_press` together → 3, not 4.
3. Enter DIE → `die_flash` reads 1,1,1,1,0,0,0,0,1,1,1,1,0,0,0,0 for k=0..15, then 1 for k=16..19. At k=20 `game_status`=0 and `lives`=1. `restart`=1 for exactly 3 cycles, then the state is 1.
4. Second death with `lives`=1 → after 20 DIE cycles `game_status`=5, `game_over`=1, `lives`=0. Then pulse `key_press` → state 0 with `lives`=2, `restart`=1 for 3 cycles, then state 1.
5. Assert `rst` at k=9 of DIE → next cycle all outputs hold reset values (state 1, `die_flash`=1, `lives`=2). Assert `rst` during RESTART → `restart` drops to 0 on the next edge.
6. Pulse `hit_body` in START, RESTART and GAMEOVER → no state change and `lives` unchanged.
